// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared types and helpers for the seven-segment scan path.
//   seg_t      : active-low segment vector {g,f,e,d,c,b,a}
//   SEG_BLANK  : all segments off
//   hex_to_seg : nibble -> active-low segment pattern (0-9, A, b, C, d, E, F)
// -----------------------------------------------------------------------------
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_to_seven_seg_decoder.sv
// -----------------------------------------------------------------------------
// hex_to_seven_seg_decoder
// Purely combinational nibble-to-segment decoder.
// Ports:
//   i_nibble : hex digit to show
//   o_seg    : active-low {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module hex_to_seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg_t       o_seg
);

  assign o_seg = hex_to_seg(i_nibble);

endmodule

// File: rtl/seven_seg_scan_controller.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_controller
// Time-multiplexes NUM_DIGITS hex nibbles onto one common-anode display.
// New values are captured into a shadow bank on 'we' and only copied to the
// displayed (active) bank at a frame boundary, so one frame never mixes two
// writes.
//
// Ports:
//   clk        : system clock
//   rst        : synchronous reset, active-high
//   we         : write strobe, captures value and dp_mask
//   value      : hex digits, nibble k -> digit k (k=0 rightmost)
//   dp_mask    : 1 = decimal point lit on digit k
//   blank_lz   : 1 = blank leading zero digits (sampled live)
//   brightness : duty setting 0..15 (only with SEVEN_SEG_BRIGHTNESS_EN)
//   anode      : active-low digit enables
//   segments   : active-low {g,f,e,d,c,b,a}
//   dp         : active-low decimal point
//   frame_tick : one-cycle pulse after the last digit's slot ends
//
// Build option: define SEVEN_SEG_BRIGHTNESS_EN to add the brightness input
// and PWM the anode within each digit slot; otherwise full duty.
// -----------------------------------------------------------------------------
module seven_seg_scan_controller
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DIV_W       = $clog2(REFRESH_DIV),
  parameter int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blank_lz,
`ifdef SEVEN_SEG_BRIGHTNESS_EN
  input  logic [3:0]              brightness,
`endif
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Scan timing
  logic [DIV_W-1:0] r_div_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             w_tc;
  logic             w_frame_wrap;

  // Write path
  logic [4*NUM_DIGITS-1:0] r_shadow_value;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [4*NUM_DIGITS-1:0] r_active_value;
  logic [NUM_DIGITS-1:0]   r_active_dp;
  logic                    r_pending;

  // Digit selection
  logic [3:0]            w_nibble;
  logic                  w_dp_bit;
  logic                  w_sel_zero;
  logic [NUM_DIGITS-1:0] w_anode_sel;
  logic                  w_blank;
  logic                  w_duty_on;
  seg_t                  w_seg;

  // Registered outputs
  logic [NUM_DIGITS-1:0] r_anode;
  seg_t                  r_segments;
  logic                  r_dp;
  logic                  r_frame_tick;

  assign w_tc         = (r_div_cnt == DIV_LAST);
  assign w_frame_wrap = w_tc && (r_idx == IDX_LAST);

  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_idx     <= '0;
    end else if (w_tc) begin
      r_div_cnt <= '0;
      r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Shadow bank absorbs writes during a frame (last write wins); the frame
  // wrap promotes it. A write landing exactly on the wrap bypasses the shadow
  // so it is not delayed by a whole frame.
  // NOTE: the value banks are plain registers, not a memory array, and are
  // reset so that rst also discards any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow_value <= '0;
      r_shadow_dp    <= '0;
      r_active_value <= '0;
      r_active_dp    <= '0;
      r_pending      <= 1'b0;
    end else if (w_frame_wrap) begin
      if (we) begin
        r_active_value <= value;
        r_active_dp    <= dp_mask;
      end else if (r_pending) begin
        r_active_value <= r_shadow_value;
        r_active_dp    <= r_shadow_dp;
      end
      r_pending <= 1'b0;
    end else if (we) begin
      r_shadow_value <= value;
      r_shadow_dp    <= dp_mask;
      r_pending      <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default before the loop; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    w_nibble    = 4'h0;
    w_dp_bit    = 1'b0;
    w_sel_zero  = 1'b0;
    w_anode_sel = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nibble       = r_active_value[4*k +: 4];
        w_dp_bit       = r_active_dp[k];
        // Digit k and everything to its left are zero -> leading zero.
        w_sel_zero     = ((r_active_value >> (4*k)) == '0);
        w_anode_sel[k] = 1'b0;
      end
    end
  end

  // Digit 0 always shows something, even for an all-zero value.
  assign w_blank = blank_lz && (r_idx != '0) && w_sel_zero;

`ifdef SEVEN_SEG_BRIGHTNESS_EN
  // Anode is on for the first (brightness+1)/16 of each slot.
  assign w_duty_on = (32'(r_div_cnt) <
                      (((32'(brightness) + 32'd1) * 32'(REFRESH_DIV)) >> 4));
`else
  assign w_duty_on = 1'b1;
`endif

  hex_to_seven_seg_decoder u_decoder (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_anode      <= '1;
      r_segments   <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_anode      <= w_duty_on ? w_anode_sel : '1;
      r_segments   <= w_blank ? SEG_BLANK : w_seg;
      r_dp         <= ~w_dp_bit;
      r_frame_tick <= w_frame_wrap;
    end
  end

  assign anode      = r_anode;
  assign segments   = r_segments;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan_controller
// Self-checking bench for a 4-digit, 16-cycle-slot configuration. The
// reference model works from the absolute cycle count since reset: slot and
// frame position come from division/modulo, and the displayed value is
// updated only at frame boundaries. Every output is compared every cycle.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_controller;

  localparam int ND    = 4;
  localparam int RD    = 16;
  localparam int FRAME = ND * RD;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [15:0]   value;
  logic [3:0]    dp_mask;
  logic          blank_lz;
  logic [3:0]    anode;
  logic [6:0]    segments;
  logic          dp;
  logic          frame_tick;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
  logic [3:0]    brightness = 4'hF;
`endif

  always #5 clk = ~clk;

  seven_seg_scan_controller #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .value      (value),
    .dp_mask    (dp_mask),
    .blank_lz   (blank_lz),
`ifdef SEVEN_SEG_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .anode      (anode),
    .segments   (segments),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  // Active-low gfedcba patterns for hex digits 0..F.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                               7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                               7'h46, 7'h21, 7'h06, 7'h0E};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int          p;          // posedges since reset release
  logic [15:0] m_active;
  logic [3:0]  m_active_dp;
  logic [15:0] m_shadow;
  logic [3:0]  m_shadow_dp;
  bit          m_pending;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, p);
    end
  endtask

  task automatic model_reset();
    p           = 0;
    m_active    = '0;
    m_active_dp = '0;
    m_shadow    = '0;
    m_shadow_dp = '0;
    m_pending   = 1'b0;
  endtask

  // Hold rst for n edges, checking the idle output state after each.
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("rst_anode", anode, 4'hF);
      check("rst_seg", segments, 7'h7F);
      check("rst_dp", dp, 1'b1);
      check("rst_tick", frame_tick, 1'b0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  // One clock edge with the currently driven inputs. Outputs after edge p
  // reflect the slot and displayed value in force just before edge p.
  task automatic step();
    int         slot;
    bit         wrap;
    logic [3:0] e_anode;
    logic [6:0] e_seg;
    logic       e_dp;
    slot    = (p / RD) % ND;
    wrap    = ((p % FRAME) == FRAME - 1);
    e_anode = ~(4'b0001 << slot);
    if (blank_lz && slot > 0 && (m_active >> (4*slot)) == 16'h0)
      e_seg = 7'h7F;
    else
      e_seg = seg_tab[(m_active >> (4*slot)) & 16'hF];
    e_dp = ~m_active_dp[slot];

    if (wrap) begin
      if (we) begin
        m_active    = value;
        m_active_dp = dp_mask;
      end else if (m_pending) begin
        m_active    = m_shadow;
        m_active_dp = m_shadow_dp;
      end
      m_pending = 1'b0;
    end else if (we) begin
      m_shadow    = value;
      m_shadow_dp = dp_mask;
      m_pending   = 1'b1;
    end

    @(posedge clk);
    #1;
    check("anode", anode, e_anode);
    check("segments", segments, e_seg);
    check("dp", dp, e_dp);
    check("frame_tick", frame_tick, wrap);
    p++;
  endtask

  task automatic idle(input int n);
    we = 1'b0;
    repeat (n) step();
  endtask

  task automatic write(input logic [15:0] v, input logic [3:0] m);
    we      = 1'b1;
    value   = v;
    dp_mask = m;
    step();
    we      = 1'b0;
  endtask

  // Idle until the next edge is at frame position 'pos'.
  task automatic align(input int pos);
    we = 1'b0;
    while ((p % FRAME) != pos) step();
  endtask

  initial begin
    rst      = 1'b1;
    we       = 1'b0;
    value    = '0;
    dp_mask  = '0;
    blank_lz = 1'b0;
    model_reset();

    do_reset(3);

    // Basic scan of 12AF, first frame shows the reset value.
    write(16'h12AF, 4'b0000);
    idle(160);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    write(16'h0042, 4'b0100);
    idle(130);
    write(16'h0000, 4'b0000);
    idle(130);
    blank_lz = 1'b0;

    // Two writes inside one frame: only the later one is ever shown.
    align(10);
    write(16'h1111, 4'b0000);
    idle(2);
    write(16'h2222, 4'b1010);
    idle(130);

    // Write on the wrap edge goes straight to the display.
    align(FRAME - 1);
    write(16'hFFFF, 4'b0001);
    idle(130);

    // Reset mid-scan with a write pending: the write must be dropped.
    align(20);
    write(16'h1234, 4'b1111);
    idle(5);
    do_reset(1);
    idle(70);

    // Randomized traffic with occasional resets and live blank_lz changes.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(15) == 0) begin
        we      = 1'b1;
        value   = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dp_mask = 4'($urandom);
      end else begin
        we = 1'b0;
      end
      if ($urandom_range(49) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(699) == 0) do_reset(1);
      else step();
    end
    idle(70);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
